// File: rtl/icache_nway_if.sv
// Fetch-side and AXI read-channel bundle of the N-way instruction cache.
// The cache connects through the slave modport, the fetch stage and fabric through master.
interface icache_nway_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cpu_req;
    logic [ADDR_WIDTH-1:0] cpu_req_addr;
    logic                  cpu_req_ready;
    logic [DATA_WIDTH-1:0] cpu_req_data;
    logic                  cpu_req_err;
    logic                  flush;
    logic                  busy;

    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;

    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    modport slave (
        input  cpu_req, cpu_req_addr, flush, arready, rvalid, rdata, rresp, rlast,
        output cpu_req_ready, cpu_req_data, cpu_req_err, busy,
        output arvalid, araddr, arlen, arsize, arburst, rready
    );

    modport master (
        output cpu_req, cpu_req_addr, flush, arready, rvalid, rdata, rresp, rlast,
        input  cpu_req_ready, cpu_req_data, cpu_req_err, busy,
        input  arvalid, araddr, arlen, arsize, arburst, rready
    );
endinterface

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with AXI INCR line refill and invalidate-all flush.
// Define ICACHE_PERF_CNT_EN to add the hit_cnt / miss_cnt lookup counters.
module icache_nway #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WAYS        = 2,
    parameter int SETS        = 16,
    parameter int BLOCK_WORDS = 8
) (
    input  logic         clk,
    input  logic         rst,
    icache_nway_if.slave bus
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
`endif
);
    localparam int OW = $clog2(BLOCK_WORDS);
    localparam int IW = $clog2(SETS);
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TW = ADDR_WIDTH - IW - OW - 2;
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_MREQ, S_REFILL, S_RESP, S_INV
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-3:0] r_addr;
    logic [WAYS-1:0]       r_valid [SETS];
    logic [WW-1:0]         r_rr    [SETS];
    logic [TW-1:0]         r_tag   [WAYS][SETS];
    logic [DATA_WIDTH-1:0] r_mem   [WAYS][SETS][BLOCK_WORDS];
    logic [WW-1:0]         r_victim;
    logic [OW:0]           r_beat_cnt;
    logic                  r_err;
    logic                  r_flush_pend;
    logic [IW-1:0]         r_inv_set;
    logic [DATA_WIDTH-1:0] r_fill_word;
    logic                  r_arvalid;
    logic                  r_rready;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic                  r_ready;
    logic                  r_err_out;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_busy;

    logic [OW-1:0]         w_off;
    logic [IW-1:0]         w_idx;
    logic [TW-1:0]         w_tag;
    logic                  w_hit;
    logic [WW-1:0]         w_hit_way;
    logic [WW-1:0]         w_vic;
    logic                  w_vic_found;
    logic                  w_beat;
    logic [OW:0]           w_cnt_next;
    logic                  w_err_final;
    logic [DATA_WIDTH-1:0] w_fill_word;
    logic [WW-1:0]         w_rr_next;
    logic                  w_unused_addr;

    assign w_off = r_addr[OW-1:0];
    assign w_idx = r_addr[OW+IW-1:OW];
    assign w_tag = r_addr[ADDR_WIDTH-3:OW+IW];
    assign w_unused_addr = ^bus.cpu_req_addr[1:0];

    assign bus.arlen         = 8'(BLOCK_WORDS - 1);
    assign bus.arsize        = 3'b010;
    assign bus.arburst       = 2'b01;
    assign bus.arvalid       = r_arvalid;
    assign bus.araddr        = r_araddr;
    assign bus.rready        = r_rready;
    assign bus.cpu_req_ready = r_ready;
    assign bus.cpu_req_err   = r_err_out;
    assign bus.cpu_req_data  = r_data_out;
    assign bus.busy          = r_busy;

    // Tag match across all ways; victim is the lowest invalid way, else the set's pointer.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_vic       = r_rr[w_idx];
        w_vic_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_hit && r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WW'(w);
            end
            if (!w_vic_found && !r_valid[w_idx][w]) begin
                w_vic_found = 1'b1;
                w_vic       = WW'(w);
            end
        end
    end

    assign w_beat      = (r_state == S_REFILL) && bus.rvalid && r_rready;
    assign w_cnt_next  = r_beat_cnt + (OW+1)'(1);
    assign w_err_final = r_err || (bus.rresp != 2'b00) || r_beat_cnt[OW]
                         || (w_cnt_next != (OW+1)'(BLOCK_WORDS));
    // The requested word may arrive on the final beat, before it reaches r_fill_word.
    assign w_fill_word = (!r_beat_cnt[OW] && (r_beat_cnt[OW-1:0] == w_off)) ? bus.rdata : r_fill_word;
    assign w_rr_next   = (r_rr[w_idx] == WW'(WAYS - 1)) ? '0 : r_rr[w_idx] + WW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_victim     <= '0;
            r_beat_cnt   <= '0;
            r_err        <= 1'b0;
            r_flush_pend <= 1'b0;
            r_inv_set    <= '0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_araddr     <= '0;
            r_ready      <= 1'b0;
            r_err_out    <= 1'b0;
            r_data_out   <= NOP;
            r_busy       <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else begin
            r_ready    <= 1'b0;
            r_err_out  <= 1'b0;
            r_data_out <= NOP;
            case (r_state)
                S_IDLE: begin
                    if (bus.flush || r_flush_pend) begin
                        r_state   <= S_INV;
                        r_busy    <= 1'b1;
                        r_inv_set <= '0;
                    end else if (bus.cpu_req) begin
                        r_addr  <= bus.cpu_req_addr[ADDR_WIDTH-1:2];
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (bus.flush) r_flush_pend <= 1'b1;
                    if (w_hit) begin
                        r_ready    <= 1'b1;
                        r_data_out <= r_mem[w_hit_way][w_idx][w_off];
                        r_state    <= S_RESP;
                    end else begin
                        r_victim            <= w_vic;
                        r_valid[w_idx][w_vic] <= 1'b0;
                        r_araddr            <= {w_tag, w_idx, {(OW+2){1'b0}}};
                        r_arvalid           <= 1'b1;
                        r_busy              <= 1'b1;
                        r_err               <= 1'b0;
                        r_beat_cnt          <= '0;
                        r_state             <= S_MREQ;
                    end
                end
                S_MREQ: begin
                    if (bus.flush) r_flush_pend <= 1'b1;
                    if (bus.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (bus.flush) r_flush_pend <= 1'b1;
                    if (bus.rvalid) begin
                        if (!r_beat_cnt[OW]) r_beat_cnt <= w_cnt_next;
                        if ((bus.rresp != 2'b00) || r_beat_cnt[OW]) r_err <= 1'b1;
                        if (bus.rlast) begin
                            r_rready   <= 1'b0;
                            r_busy     <= 1'b0;
                            r_ready    <= 1'b1;
                            r_err      <= w_err_final;
                            r_err_out  <= w_err_final;
                            r_data_out <= w_err_final ? NOP : w_fill_word;
                            if (!w_err_final) begin
                                r_valid[w_idx][r_victim] <= 1'b1;
                                r_rr[w_idx]              <= w_rr_next;
                            end
                            r_state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (bus.flush || r_flush_pend) begin
                        r_state   <= S_INV;
                        r_busy    <= 1'b1;
                        r_inv_set <= '0;
                    end else if (bus.cpu_req) begin
                        r_addr  <= bus.cpu_req_addr[ADDR_WIDTH-1:2];
                        r_state <= S_LOOKUP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_INV: begin
                    r_valid[r_inv_set] <= '0;
                    if (r_inv_set == IW'(SETS - 1)) begin
                        r_flush_pend <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_inv_set <= r_inv_set + IW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag and line storage carry no reset; validity alone decides whether they are used.
    always_ff @(posedge clk) begin
        if ((r_state == S_LOOKUP) && !w_hit) r_tag[w_vic][w_idx] <= w_tag;
        if (w_beat && !r_beat_cnt[OW]) begin
            r_mem[r_victim][w_idx][r_beat_cnt[OW-1:0]] <= bus.rdata;
            if (r_beat_cnt[OW-1:0] == w_off) r_fill_word <= bus.rdata;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
            else       r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif
endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway with default geometry: tag [31:9], index [8:5], word [4:2].
// Covers ICACHE_PERF_CNT_EN when that macro is defined for the build.
module tb_icache_nway;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    icache_nway_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache_nway dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic do_hit(input logic [31:0] a, output logic rdy0, output logic rdy,
                          output logic [31:0] d, output logic e, output logic arv);
        bus.cpu_req = 1'b1;
        bus.cpu_req_addr = a;
        tick;
        bus.cpu_req = 1'b0;
        rdy0 = bus.cpu_req_ready;
        arv  = bus.arvalid;
        tick;
        rdy = bus.cpu_req_ready;
        d   = bus.cpu_req_data;
        e   = bus.cpu_req_err;
        arv = arv | bus.arvalid;
    endtask

    task automatic do_miss(input logic [31:0] a, input logic [31:0] base, input int err_beat,
                           input int flush_beat, output logic [31:0] ara, output logic to,
                           output logic rdy, output logic [31:0] d, output logic e);
        int c;
        bus.cpu_req = 1'b1;
        bus.cpu_req_addr = a;
        tick;
        bus.cpu_req = 1'b0;
        to = 1'b0; ara = '0; rdy = 1'b0; d = '0; e = 1'b0;
        c = 0;
        while (!bus.arvalid && c < 20) begin
            tick;
            c++;
        end
        if (!bus.arvalid) begin
            to = 1'b1;
            return;
        end
        ara = bus.araddr;
        bus.arready = 1'b1;
        tick;
        bus.arready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.rvalid = 1'b1;
            bus.rdata  = base + 32'(i);
            bus.rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            bus.rlast  = (i == 7);
            bus.flush  = (i == flush_beat);
            tick;
        end
        bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rresp = 2'b00; bus.flush = 1'b0;
        rdy = bus.cpu_req_ready;
        d   = bus.cpu_req_data;
        e   = bus.cpu_req_err;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (bus.arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid got=%b exp=0", bus.arvalid); end
        checks++; if (bus.rready !== 1'b0) begin failures++; $display("FAIL reset_rready got=%b exp=0", bus.rready); end
        checks++; if (bus.cpu_req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.cpu_req_ready); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.araddr !== 32'h0) begin failures++; $display("FAIL reset_araddr got=%h exp=0", bus.araddr); end
        checks++; if (bus.cpu_req_data !== 32'h13) begin failures++; $display("FAIL reset_data got=%h exp=00000013", bus.cpu_req_data); end
        checks++; if ({bus.arlen, bus.arsize, bus.arburst} !== {8'd7, 3'd2, 2'd1}) begin
            failures++; $display("FAIL ar_const got=%0d/%0d/%0d exp=7/2/1", bus.arlen, bus.arsize, bus.arburst); end
    endtask

    task automatic test_cold_miss;
        logic [31:0] ara, d; logic to, rdy, e;
        do_miss(32'h040, 32'h1000, -1, -1, ara, to, rdy, d, e);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL cold_arvalid timeout got=1 exp=0"); end
        checks++; if (ara !== 32'h040) begin failures++; $display("FAIL cold_araddr got=%h exp=00000040", ara); end
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL cold_ready got=%b exp=1", rdy); end
        checks++; if (d !== 32'h1000) begin failures++; $display("FAIL cold_data got=%h exp=00001000", d); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL cold_err got=%b exp=0", e); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL cold_busy got=%b exp=0", bus.busy); end
        tick;
        checks++; if (bus.cpu_req_ready !== 1'b0) begin failures++; $display("FAIL cold_ready_pulse got=%b exp=0", bus.cpu_req_ready); end
    endtask

    task automatic test_hit;
        logic rdy0, rdy, e, arv; logic [31:0] d;
        do_hit(32'h044, rdy0, rdy, d, e, arv);
        checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL hit_early_ready got=%b exp=0", rdy0); end
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL hit_ready got=%b exp=1", rdy); end
        checks++; if (d !== 32'h1001) begin failures++; $display("FAIL hit_data got=%h exp=00001001", d); end
        checks++; if (arv !== 1'b0) begin failures++; $display("FAIL hit_arvalid got=%b exp=0", arv); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL hit_err got=%b exp=0", e); end
        tick;
    endtask

    task automatic test_back_to_back;
        bus.cpu_req = 1'b1;
        bus.cpu_req_addr = 32'h040;
        tick;
        tick;
        checks++; if ({bus.cpu_req_ready, bus.cpu_req_data} !== {1'b1, 32'h1000}) begin
            failures++; $display("FAIL b2b_first got=%b/%h exp=1/00001000", bus.cpu_req_ready, bus.cpu_req_data); end
        bus.cpu_req_addr = 32'h048;
        tick;
        bus.cpu_req = 1'b0;
        checks++; if (bus.cpu_req_ready !== 1'b0) begin failures++; $display("FAIL b2b_gap got=%b exp=0", bus.cpu_req_ready); end
        tick;
        checks++; if ({bus.cpu_req_ready, bus.cpu_req_data} !== {1'b1, 32'h1002}) begin
            failures++; $display("FAIL b2b_second got=%b/%h exp=1/00001002", bus.cpu_req_ready, bus.cpu_req_data); end
        tick;
    endtask

    task automatic test_replacement;
        logic [31:0] ara, d; logic to, rdy, e, rdy0, arv;
        do_reset;
        do_miss(32'h040, 32'h2000, -1, -1, ara, to, rdy, d, e);
        do_miss(32'h240, 32'h3000, -1, -1, ara, to, rdy, d, e);
        checks++; if ({to, ara, d} !== {1'b0, 32'h240, 32'h3000}) begin
            failures++; $display("FAIL repl_fill240 got=%b/%h/%h exp=0/00000240/00003000", to, ara, d); end
        do_miss(32'h440, 32'h4000, -1, -1, ara, to, rdy, d, e);
        checks++; if ({to, ara} !== {1'b0, 32'h440}) begin failures++; $display("FAIL repl_fill440 got=%b/%h exp=0/00000440", to, ara); end
        do_hit(32'h240, rdy0, rdy, d, e, arv);
        checks++; if ({arv, rdy, d} !== {1'b0, 1'b1, 32'h3000}) begin
            failures++; $display("FAIL repl_hit240 got=%b/%b/%h exp=0/1/00003000", arv, rdy, d); end
        do_miss(32'h040, 32'h5000, -1, -1, ara, to, rdy, d, e);
        checks++; if ({to, ara, d} !== {1'b0, 32'h040, 32'h5000}) begin
            failures++; $display("FAIL repl_miss040 got=%b/%h/%h exp=0/00000040/00005000", to, ara, d); end
        do_hit(32'h444, rdy0, rdy, d, e, arv);
        checks++; if ({arv, rdy, d} !== {1'b0, 1'b1, 32'h4001}) begin
            failures++; $display("FAIL repl_keep440 got=%b/%b/%h exp=0/1/00004001", arv, rdy, d); end
        do_miss(32'h240, 32'h6000, -1, -1, ara, to, rdy, d, e);
        checks++; if ({to, ara} !== {1'b0, 32'h240}) begin failures++; $display("FAIL repl_evict240 got=%b/%h exp=0/00000240", to, ara); end
        tick;
    endtask

    task automatic test_flush_idle;
        logic [31:0] ara, d; logic to, rdy, e;
        int cnt;
        bus.flush = 1'b1;
        tick;
        bus.flush = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.busy) cnt++;
            else break;
            tick;
        end
        checks++; if (cnt !== 16) begin failures++; $display("FAIL flush_idle_busy_cycles got=%0d exp=16", cnt); end
        do_miss(32'h044, 32'h8000, -1, -1, ara, to, rdy, d, e);
        checks++; if ({to, ara, d} !== {1'b0, 32'h040, 32'h8001}) begin
            failures++; $display("FAIL flush_idle_remiss got=%b/%h/%h exp=0/00000040/00008001", to, ara, d); end
        tick;
    endtask

    task automatic test_flush_refill;
        logic [31:0] ara, d; logic to, rdy, e;
        int cnt;
        do_miss(32'h0A0, 32'hA000, -1, 2, ara, to, rdy, d, e);
        checks++; if ({to, rdy, d, e} !== {1'b0, 1'b1, 32'hA000, 1'b0}) begin
            failures++; $display("FAIL flush_refill_resp got=%b/%b/%h/%b exp=0/1/0000a000/0", to, rdy, d, e); end
        tick;
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL flush_refill_inv_start got=%b exp=1", bus.busy); end
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.busy) cnt++;
            else break;
            tick;
        end
        checks++; if (cnt !== 16) begin failures++; $display("FAIL flush_refill_busy_cycles got=%0d exp=16", cnt); end
        do_miss(32'h0A0, 32'hB000, -1, -1, ara, to, rdy, d, e);
        checks++; if ({to, ara} !== {1'b0, 32'h0A0}) begin failures++; $display("FAIL flush_refill_remiss got=%b/%h exp=0/000000a0", to, ara); end
        tick;
    endtask

    task automatic test_error;
        logic [31:0] ara, d; logic to, rdy, e, rdy0, arv;
        do_miss(32'h060, 32'h6000, 3, -1, ara, to, rdy, d, e);
        checks++; if ({to, rdy, e} !== {1'b0, 1'b1, 1'b1}) begin
            failures++; $display("FAIL err_resp got=%b/%b/%b exp=0/1/1", to, rdy, e); end
        checks++; if (d !== 32'h13) begin failures++; $display("FAIL err_data got=%h exp=00000013", d); end
        do_miss(32'h060, 32'h7000, -1, -1, ara, to, rdy, d, e);
        checks++; if ({to, ara, d, e} !== {1'b0, 32'h060, 32'h7000, 1'b0}) begin
            failures++; $display("FAIL err_refetch got=%b/%h/%h/%b exp=0/00000060/00007000/0", to, ara, d, e); end
        do_hit(32'h064, rdy0, rdy, d, e, arv);
        checks++; if ({arv, rdy, d} !== {1'b0, 1'b1, 32'h7001}) begin
            failures++; $display("FAIL err_after_hit got=%b/%b/%h exp=0/1/00007001", arv, rdy, d); end
        tick;
    endtask

`ifdef ICACHE_PERF_CNT_EN
    task automatic test_perf;
        logic [31:0] ara, d; logic to, rdy, e, rdy0, arv;
        do_reset;
        checks++; if ({hit_cnt, miss_cnt} !== 64'h0) begin failures++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
        do_miss(32'h100, 32'hC000, -1, -1, ara, to, rdy, d, e);
        do_hit(32'h104, rdy0, rdy, d, e, arv);
        do_hit(32'h108, rdy0, rdy, d, e, arv);
        do_miss(32'h300, 32'hD000, -1, -1, ara, to, rdy, d, e);
        tick;
        checks++; if (hit_cnt !== 32'd2) begin failures++; $display("FAIL perf_hits got=%0d exp=2", hit_cnt); end
        checks++; if (miss_cnt !== 32'd2) begin failures++; $display("FAIL perf_misses got=%0d exp=2", miss_cnt); end
    endtask
`endif

    task automatic test_reset_midburst;
        logic [31:0] ara, d; logic to, rdy, e;
        int c;
        bus.cpu_req = 1'b1;
        bus.cpu_req_addr = 32'h0C0;
        tick;
        bus.cpu_req = 1'b0;
        c = 0;
        while (!bus.arvalid && c < 20) begin
            tick;
            c++;
        end
        checks++; if (bus.arvalid !== 1'b1) begin failures++; $display("FAIL midrst_arvalid got=%b exp=1", bus.arvalid); end
        bus.arready = 1'b1;
        tick;
        bus.arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.rvalid = 1'b1;
            bus.rdata  = 32'hE000 + 32'(i);
            tick;
        end
        bus.rvalid = 1'b0;
        checks++; if (bus.rready !== 1'b1) begin failures++; $display("FAIL midrst_in_refill got=%b exp=1", bus.rready); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++; if ({bus.arvalid, bus.rready, bus.busy} !== 3'b000) begin
            failures++; $display("FAIL midrst_outputs got=%b%b%b exp=000", bus.arvalid, bus.rready, bus.busy); end
`ifdef ICACHE_PERF_CNT_EN
        checks++; if ({hit_cnt, miss_cnt} !== 64'h0) begin failures++; $display("FAIL midrst_counters got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
`endif
        do_miss(32'h0C4, 32'hF000, -1, -1, ara, to, rdy, d, e);
        checks++; if ({to, ara, d} !== {1'b0, 32'h0C0, 32'hF001}) begin
            failures++; $display("FAIL midrst_remiss got=%b/%h/%h exp=0/000000c0/0000f001", to, ara, d); end
        tick;
    endtask

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_req_addr = '0; bus.flush = 1'b0;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00; bus.rlast = 1'b0;
        #2;
        test_reset;
        test_cold_miss;
        test_hit;
        test_back_to_back;
        test_replacement;
        test_flush_idle;
        test_flush_refill;
        test_error;
`ifdef ICACHE_PERF_CNT_EN
        test_perf;
`endif
        test_reset_midburst;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
